waterfall_scroller: RTL and testbench
=====================================

Name: waterfall_scroller

Overview:
Parametrised controller for the scrolling waterfall frame buffer. It sits between the video timing block, the frequency-bin BRAM and the single-port frame-buffer SPRAM, all on the pixel clock.
- During the visible region it generates read addresses so that display row y maps to buffer row (y + top_row) mod V_VISIBLE.
- During lower blanking it copies one line of bins into the buffer and then moves the scroll origin.
- Beyond the current hard-wired scroller it adds: arbitrary geometry, runtime scroll-rate divider, freeze, scroll direction, on-demand clear, and correct row wrap.

Parameters:
- H_VISIBLE, 320, pixels per line.
- V_VISIBLE, 240, lines per frame.
- LINE_BINS, 320, bins copied per line (must be ≤ H_VISIBLE); pixels at index LINE_BINS..H_VISIBLE-1 are written 0.
- PIX_W, 8, pixel/bin data width.
- BIN_ADDR_W, 9, bin BRAM address width.
- FB_ADDR_W, 17, frame-buffer address width (must be ≥ clog2(H_VISIBLE*V_VISIBLE)).
- DIV_W, 4, scroll divider width.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- x  in  9  video column.
- y  in  8  video row.
- lower_blank  in  1  high during vertical blanking after the last visible line.
- scroll_div  in  DIV_W  a line is written every scroll_div+1 frames.
- scroll_dir  in  1  0 = newest line at bottom (scroll up); 1 = newest line at top (scroll down).
- freeze  in  1  suppress line writes.
- clear_req  in  1  request a full buffer clear; sticky until serviced.
- bin_addr  out  BIN_ADDR_W  bin BRAM read address.
- bin_en  out  1  bin BRAM read enable.
- bin_data  in  PIX_W  bin BRAM read data, valid 1 cycle after bin_addr/bin_en.
- fb_addr  out  FB_ADDR_W  frame-buffer address.
- fb_wdata  out  PIX_W  frame-buffer write data.
- fb_wen  out  1  frame-buffer write enable.
- top_row  out  8  current scroll origin (buffer row shown at y=0).
- line_done  out  1  one-cycle pulse after each line write completes.
- clear_busy  out  1  high while clearing.

Behaviour:
- Reset values: all outputs 0; top_row=0; frame counter=0; clear-pending flag=1; state=CLEAR.
- States and transitions:
  - CLEAR: fb_wen=1, fb_wdata=0, fb_addr steps 0..H*V-1, one address per cycle. After the last address: fb_wen=0, clear_busy=0, clear-pending flag=0, top_row=0, go WAIT_END. clear_busy=1 throughout.
  - VIDEO: registered fb_addr = x + ((y+top_row) mod V)*H, 1-cycle latency; fb_wen=0.
    - Modulo by a single conditional subtract; row*H by constant multiply.
    - On the first cycle of lower_blank:
      - if clear-pending → CLEAR;
      - else if freeze → WAIT_END (frame counter held);
      - else if frame counter == scroll_div → counter=0, go LINE;
      - else counter+1, WAIT_END.
  - LINE: write row r = top_row (dir 0) or (top_row-1) mod V (dir 1); r is latched at entry.
    - Cycle k drives bin_addr=k with bin_en=1 for k<LINE_BINS.
    - Cycle k+1 writes fb_addr = r*H + k with fb_wdata = bin_data, or 0 for k ≥ LINE_BINS.
    - Exactly H_VISIBLE writes, duration H_VISIBLE+1 cycles.
    - On completion: line_done pulse; top_row = (r+1) mod V for dir 0, or r for dir 1; go WAIT_END.
  - WAIT_END: fb_wen=0; return to VIDEO when lower_blank deasserts.
- Row wrap: top_row wraps V-1→0 (dir 0) and 0→V-1 (dir 1); it never holds V_VISIBLE.
- scroll_dir and scroll_div are sampled only at the lower_blank decision. Changing them mid-line has no effect until the next frame.
- clear_req arriving in any state sets the pending flag; it is serviced at the next lower_blank entry. A clear_req during CLEAR is absorbed.
- lower_blank deasserting during LINE or CLEAR: the operation completes anyway. Video reads meanwhile see stale addresses (accepted artefact). The state then returns to VIDEO directly, because lower_blank is already low.
- resetn asserted mid-operation: immediate return to reset values; a partial line is abandoned and a full clear follows.

Decomposition:
- Shared package (waterfall_pkg): state encoding localparams, and the H_VISIBLE/V_VISIBLE defaults shared with the video block.
- One natural sub-module, row_addr_gen: combinational (row, col) → row*H + col plus the mod-V add/subtract helpers. It is reused by the VIDEO and LINE paths.

Test Plan:
All tests use H=8, V=4, LINE_BINS=6, DIV_W=4.
1. Reset release → 32 writes of 0 to fb_addr 0..31; clear_busy high for 32 cycles; top_row=0.
2. scroll_div=0, dir=0, bin_data=bin_addr+10 → at each blank, writes to 0..7 data 10..15,0,0; next line at 8..15; top_row 1,2,3,0; line_done once per frame.
3. scroll_div=2, dir=0 → line writes occur only in frames 3,6,9; freeze=1 across one due frame → no write, and the counter resumes without skipping.
4. dir=1 from top_row=0 → first line written at row 3 (fb_addr 24..31), top_row=3; then row 2, top_row=2.
5. top_row=1, video x=5,y=3 → fb_addr=5 one cycle later (row (3+1) mod 4 = 0); y=2 → fb_addr=29.
6. clear_req pulse mid-frame, then resetn low mid-LINE → after reset release, a clear runs first; the partial line is not completed and top_row=0.

Source files
------------

// File: rtl/waterfall_pkg.sv
// Shared definitions for the waterfall scroller: controller states and the
// default visible geometry shared with the video timing block.
package waterfall_pkg;

   localparam int H_VISIBLE_DEF = 320;
   localparam int V_VISIBLE_DEF = 240;

   typedef enum logic [1:0] {
      ST_CLEAR    = 2'd0,
      ST_VIDEO    = 2'd1,
      ST_LINE     = 2'd2,
      ST_WAIT_END = 2'd3
   } state_t;

endpackage

// File: rtl/row_addr_gen.sv
// Combinational frame-buffer address generator: ((row_a + row_b) mod V) * H + col,
// plus the mod-V increment/decrement of a scroll row.
module row_addr_gen
   import waterfall_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int FB_ADDR_W = 17
) (
   input  logic [7:0]           row_a,
   input  logic [7:0]           row_b,
   input  logic [8:0]           col,
   input  logic [7:0]           step_row,
   output logic [FB_ADDR_W-1:0] addr,
   output logic [7:0]           step_inc,
   output logic [7:0]           step_dec
);

   logic [8:0] row_sum;
   logic [7:0] sum_row;
   logic [8:0] step_sum;

   // Both operands are below V, so one conditional subtract is a full modulo.
   always_comb begin
      row_sum = {1'b0, row_a} + {1'b0, row_b};
      sum_row = row_sum[7:0];
      if (row_sum >= 9'(V_VISIBLE)) begin
         sum_row = 8'(row_sum - 9'(V_VISIBLE));
      end
      addr = FB_ADDR_W'(sum_row) * FB_ADDR_W'(H_VISIBLE) + FB_ADDR_W'(col);

      step_sum = {1'b0, step_row} + 9'd1;
      step_inc = step_sum[7:0];
      if (step_sum >= 9'(V_VISIBLE)) begin
         step_inc = 8'd0;
      end
      step_dec = (step_row == 8'd0) ? 8'(V_VISIBLE - 1) : step_row - 8'd1;
   end

endmodule

// File: rtl/waterfall_scroller.sv
// Scrolling waterfall controller: maps video reads through the scroll origin and,
// during lower blanking, copies one line of bins into the frame buffer or clears it.
module waterfall_scroller
   import waterfall_pkg::*;
#(
   parameter int H_VISIBLE  = H_VISIBLE_DEF,
   parameter int V_VISIBLE  = V_VISIBLE_DEF,
   parameter int LINE_BINS  = 320,
   parameter int PIX_W      = 8,
   parameter int BIN_ADDR_W = 9,
   parameter int FB_ADDR_W  = 17,
   parameter int DIV_W      = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [8:0]            x,
   input  logic [7:0]            y,
   input  logic                  lower_blank,
   input  logic [DIV_W-1:0]      scroll_div,
   input  logic                  scroll_dir,
   input  logic                  freeze,
   input  logic                  clear_req,
   output logic [BIN_ADDR_W-1:0] bin_addr,
   output logic                  bin_en,
   input  logic [PIX_W-1:0]      bin_data,
   output logic [FB_ADDR_W-1:0]  fb_addr,
   output logic [PIX_W-1:0]      fb_wdata,
   output logic                  fb_wen,
   output logic [7:0]            top_row,
   output logic                  line_done,
   output logic                  clear_busy
);

   localparam logic [FB_ADDR_W-1:0] LAST_CLR = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
   localparam logic [FB_ADDR_W-1:0] LINE_END = FB_ADDR_W'(H_VISIBLE);
   localparam logic [FB_ADDR_W-1:0] BINS     = FB_ADDR_W'(LINE_BINS);

   state_t                  state_q, state_d;
   logic [FB_ADDR_W-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0]        frame_q, frame_d;
   logic                    pend_q, pend_d;
   logic [7:0]              top_row_q, top_row_d;
   logic [7:0]              row_q, row_d;
   logic                    dir_q, dir_d;
   logic                    lb_q, lb_d;
   logic [FB_ADDR_W-1:0]    fb_addr_q, fb_addr_d;
   logic                    fb_wen_q, fb_wen_d;
   logic                    use_bin_q, use_bin_d;
   logic [BIN_ADDR_W-1:0]   bin_addr_q, bin_addr_d;
   logic                    bin_en_q, bin_en_d;
   logic                    done_q, done_d;
   logic                    line_done_q, line_done_d;
   logic                    clear_busy_q, clear_busy_d;

   logic [7:0]              gen_row_a, gen_row_b, gen_step;
   logic [8:0]              gen_col;
   logic [FB_ADDR_W-1:0]    gen_addr;
   logic [7:0]              gen_inc, gen_dec;

   // One address generator serves both paths; LINE steers it to the latched row.
   always_comb begin
      gen_row_a = y;
      gen_row_b = top_row_q;
      gen_col   = x;
      gen_step  = top_row_q;
      if (state_q == ST_LINE) begin
         gen_row_a = row_q;
         gen_row_b = 8'd0;
         gen_col   = 9'(cnt_q - FB_ADDR_W'(1));
         gen_step  = row_q;
      end
   end

   row_addr_gen #(
      .H_VISIBLE (H_VISIBLE),
      .V_VISIBLE (V_VISIBLE),
      .FB_ADDR_W (FB_ADDR_W)
   ) u_row_addr_gen (
      .row_a    (gen_row_a),
      .row_b    (gen_row_b),
      .col      (gen_col),
      .step_row (gen_step),
      .addr     (gen_addr),
      .step_inc (gen_inc),
      .step_dec (gen_dec)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_d      = frame_q;
      pend_d       = pend_q | clear_req;
      top_row_d    = top_row_q;
      row_d        = row_q;
      dir_d        = dir_q;
      lb_d         = lower_blank;
      fb_addr_d    = gen_addr;
      fb_wen_d     = 1'b0;
      use_bin_d    = 1'b0;
      bin_addr_d   = '0;
      bin_en_d     = 1'b0;
      done_d       = 1'b0;
      line_done_d  = done_q;
      clear_busy_d = 1'b0;

      unique case (state_q)
         ST_CLEAR: begin
            pend_d       = 1'b1;
            fb_addr_d    = cnt_q;
            fb_wen_d     = 1'b1;
            clear_busy_d = 1'b1;
            if (cnt_q == LAST_CLR) begin
               cnt_d     = '0;
               pend_d    = 1'b0;
               top_row_d = 8'd0;
               state_d   = lower_blank ? ST_WAIT_END : ST_VIDEO;
            end else begin
               cnt_d = cnt_q + FB_ADDR_W'(1);
            end
         end

         ST_VIDEO: begin
            if (lower_blank && !lb_q) begin
               if (pend_q) begin
                  cnt_d   = '0;
                  state_d = ST_CLEAR;
               end else if (freeze) begin
                  state_d = ST_WAIT_END;
               end else if (frame_q == scroll_div) begin
                  frame_d = '0;
                  row_d   = scroll_dir ? gen_dec : top_row_q;
                  dir_d   = scroll_dir;
                  cnt_d   = '0;
                  state_d = ST_LINE;
               end else begin
                  frame_d = frame_q + DIV_W'(1);
                  state_d = ST_WAIT_END;
               end
            end
         end

         // Bin read for index cnt and buffer write for index cnt-1 overlap.
         ST_LINE: begin
            if (cnt_q < BINS) begin
               bin_en_d   = 1'b1;
               bin_addr_d = BIN_ADDR_W'(cnt_q);
            end
            if (cnt_q != '0) begin
               fb_wen_d  = 1'b1;
               use_bin_d = (cnt_q <= BINS);
            end
            if (cnt_q == LINE_END) begin
               cnt_d     = '0;
               done_d    = 1'b1;
               top_row_d = dir_q ? row_q : gen_inc;
               state_d   = lower_blank ? ST_WAIT_END : ST_VIDEO;
            end else begin
               cnt_d = cnt_q + FB_ADDR_W'(1);
            end
         end

         ST_WAIT_END: begin
            if (!lower_blank) begin
               state_d = ST_VIDEO;
            end
         end

         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_CLEAR;
         cnt_q        <= '0;
         frame_q      <= '0;
         pend_q       <= 1'b1;
         top_row_q    <= 8'd0;
         row_q        <= 8'd0;
         dir_q        <= 1'b0;
         lb_q         <= 1'b0;
         fb_addr_q    <= '0;
         fb_wen_q     <= 1'b0;
         use_bin_q    <= 1'b0;
         bin_addr_q   <= '0;
         bin_en_q     <= 1'b0;
         done_q       <= 1'b0;
         line_done_q  <= 1'b0;
         clear_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_q      <= frame_d;
         pend_q       <= pend_d;
         top_row_q    <= top_row_d;
         row_q        <= row_d;
         dir_q        <= dir_d;
         lb_q         <= lb_d;
         fb_addr_q    <= fb_addr_d;
         fb_wen_q     <= fb_wen_d;
         use_bin_q    <= use_bin_d;
         bin_addr_q   <= bin_addr_d;
         bin_en_q     <= bin_en_d;
         done_q       <= done_d;
         line_done_q  <= line_done_d;
         clear_busy_q <= clear_busy_d;
      end
   end

   // Write data comes straight from the BRAM, which is valid during the write cycle.
   assign fb_wdata   = use_bin_q ? bin_data : '0;
   assign fb_addr    = fb_addr_q;
   assign fb_wen     = fb_wen_q;
   assign bin_addr   = bin_addr_q;
   assign bin_en     = bin_en_q;
   assign top_row    = top_row_q;
   assign line_done  = line_done_q;
   assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_waterfall_scroller.sv
// Self-checking bench for waterfall_scroller at H=8, V=4, LINE_BINS=6: a frame-level
// model predicts every buffer write, the scroll origin and the video read addresses.
module tb_waterfall_scroller;

   localparam int H          = 8;
   localparam int V          = 4;
   localparam int LB         = 6;
   localparam int PIX_W      = 8;
   localparam int BIN_ADDR_W = 9;
   localparam int FB_ADDR_W  = 17;
   localparam int DIV_W      = 4;
   localparam int BLANK_CYC  = 40;

   logic                  clk = 1'b0;
   logic                  resetn;
   logic [8:0]            x;
   logic [7:0]            y;
   logic                  lower_blank;
   logic [DIV_W-1:0]      scroll_div;
   logic                  scroll_dir;
   logic                  freeze;
   logic                  clear_req;
   logic [BIN_ADDR_W-1:0] bin_addr;
   logic                  bin_en;
   logic [PIX_W-1:0]      bin_data = '0;
   logic [FB_ADDR_W-1:0]  fb_addr;
   logic [PIX_W-1:0]      fb_wdata;
   logic                  fb_wen;
   logic [7:0]            top_row;
   logic                  line_done;
   logic                  clear_busy;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  done_cnt = 0;
   int  busy_cnt = 0;
   bit  vid_arm = 1'b0;
   bit  vid_chk = 1'b0;
   int  vid_exp = 0;

   // Reference model state: scroll origin, frame counter, clear pending
   int  m_top = 0;
   int  m_cnt = 0;
   bit  m_pend = 1'b1;

   logic [PIX_W-1:0] fb_mem [H*V];

   waterfall_scroller #(
      .H_VISIBLE  (H),
      .V_VISIBLE  (V),
      .LINE_BINS  (LB),
      .PIX_W      (PIX_W),
      .BIN_ADDR_W (BIN_ADDR_W),
      .FB_ADDR_W  (FB_ADDR_W),
      .DIV_W      (DIV_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .x           (x),
      .y           (y),
      .lower_blank (lower_blank),
      .scroll_div  (scroll_div),
      .scroll_dir  (scroll_dir),
      .freeze      (freeze),
      .clear_req   (clear_req),
      .bin_addr    (bin_addr),
      .bin_en      (bin_en),
      .bin_data    (bin_data),
      .fb_addr     (fb_addr),
      .fb_wdata    (fb_wdata),
      .fb_wen      (fb_wen),
      .top_row     (top_row),
      .line_done   (line_done),
      .clear_busy  (clear_busy)
   );

   always #5 clk = ~clk;

   // Bin BRAM stand-in: one-cycle read latency, contents are address + 10
   always @(posedge clk) begin
      if (bin_en) bin_data <= PIX_W'(bin_addr + 9'd10);
   end

   // Frame-buffer SPRAM stand-in
   always @(posedge clk) begin
      if (fb_wen) fb_mem[fb_addr[4:0]] <= fb_wdata;
   end

   // Compare process: every write against the predicted queue, every armed video read
   always @(negedge clk) begin
      wr_t e;
      if (resetn) begin
         if (fb_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                        fb_addr, fb_wdata);
            end else begin
               e = exp_q.pop_front();
               if (int'(fb_addr) != e.addr || int'(fb_wdata) != e.data) begin
                  failures++;
                  $display("[TB] FAIL fb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           fb_addr, fb_wdata, e.addr, e.data);
               end
            end
         end
         if (line_done) done_cnt++;
         if (clear_busy) busy_cnt++;
         if (vid_chk) begin
            checks++;
            if (int'(fb_addr) != vid_exp) begin
               failures++;
               $display("[TB] FAIL video_addr: got %0d, required %0d", fb_addr, vid_exp);
            end
         end
      end
      vid_chk = vid_arm;
      vid_arm = 1'b0;
   end

   function automatic int vidAddr(input int xx, input int yy, input int top);
      return xx + ((yy + top) % V) * H;
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One video read; req < 0 means take the expectation from the model
   task automatic applyStimulus(input int xx, input int yy, input int req);
      @(posedge clk);
      #1;
      x = 9'(xx);
      y = 8'(yy);
      vid_exp = (req < 0) ? vidAddr(xx, yy, m_top) : req;
      vid_arm = 1'b1;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic pushClear();
      for (int k = 0; k < H * V; k++) exp_q.push_back('{addr: k, data: 0});
   endtask

   task automatic pushLine(input int r);
      for (int k = 0; k < H; k++) exp_q.push_back('{addr: r * H + k, data: (k < LB) ? k + 10 : 0});
   endtask

   task automatic runFrame(input int div, input int dir, input bit frz, input bit clr);
      int lines0, busy0, exp_lines, exp_busy, r;
      scroll_div = DIV_W'(div);
      scroll_dir = dir[0];
      freeze     = frz;
      applyStimulus($urandom_range(H - 1), $urandom_range(V - 1), -1);
      if (clr) begin
         @(posedge clk);
         #1 clear_req = 1'b1;
         @(posedge clk);
         #1 clear_req = 1'b0;
         m_pend = 1'b1;
      end
      applyStimulus($urandom_range(H - 1), $urandom_range(V - 1), -1);

      exp_lines = 0;
      exp_busy  = 0;
      if (m_pend) begin
         pushClear();
         m_pend   = 1'b0;
         m_top    = 0;
         exp_busy = H * V;
      end else if (frz) begin
         exp_lines = 0;
      end else if (m_cnt == div) begin
         m_cnt = 0;
         r = dir[0] ? (m_top + V - 1) % V : m_top;
         pushLine(r);
         m_top = dir[0] ? r : (r + 1) % V;
         exp_lines = 1;
      end else begin
         m_cnt++;
      end

      lines0 = done_cnt;
      busy0  = busy_cnt;
      @(posedge clk);
      #1 lower_blank = 1'b1;
      repeat (BLANK_CYC) @(posedge clk);
      #1 lower_blank = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("writes_drained", exp_q.size(), 0);
      checkOutput("line_done_count", done_cnt - lines0, exp_lines);
      checkOutput("clear_busy_cycles", busy_cnt - busy0, exp_busy);
      checkOutput("top_row", int'(top_row), m_top);
      exp_q.delete();
   endtask

   initial begin
      int lines0, busy0;
      int lit_top [4];
      lit_top = '{1, 2, 3, 0};

      resetn      = 1'b0;
      x           = '0;
      y           = '0;
      lower_blank = 1'b0;
      scroll_div  = '0;
      scroll_dir  = 1'b0;
      freeze      = 1'b0;
      clear_req   = 1'b0;

      // Reset state and the power-on clear
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_fb_wen", int'(fb_wen), 0);
      checkOutput("reset_clear_busy", int'(clear_busy), 0);
      checkOutput("reset_top_row", int'(top_row), 0);
      checkOutput("reset_line_done", int'(line_done), 0);
      checkOutput("reset_bin_en", int'(bin_en), 0);
      checkOutput("reset_fb_addr", int'(fb_addr), 0);
      pushClear();
      busy0 = busy_cnt;
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (BLANK_CYC) @(posedge clk);
      #2;
      checkOutput("t1_clear_writes_drained", exp_q.size(), 0);
      checkOutput("t1_clear_busy_cycles", busy_cnt - busy0, 32);
      checkOutput("t1_top_row", int'(top_row), 0);
      m_pend = 1'b0;

      // Every-frame scrolling upwards
      for (int i = 0; i < 4; i++) begin
         runFrame(0, 0, 1'b0, 1'b0);
         checkOutput("t2_top_row_lit", int'(top_row), lit_top[i]);
         if (i == 0) begin
            checkOutput("t2_mem0", int'(fb_mem[0]), 10);
            checkOutput("t2_mem5", int'(fb_mem[5]), 15);
            checkOutput("t2_mem6", int'(fb_mem[6]), 0);
            checkOutput("t2_mem7", int'(fb_mem[7]), 0);
         end
         if (i == 1) checkOutput("t2_mem8", int'(fb_mem[8]), 10);
      end

      // Divided rate, then freeze across one due frame
      lines0 = done_cnt;
      for (int i = 0; i < 9; i++) runFrame(2, 0, 1'b0, 1'b0);
      checkOutput("t3_lines_in_9_frames", done_cnt - lines0, 3);
      checkOutput("t3_top_row_lit", int'(top_row), 3);
      lines0 = done_cnt;
      runFrame(2, 0, 1'b0, 1'b0);
      runFrame(2, 0, 1'b0, 1'b0);
      runFrame(2, 0, 1'b1, 1'b0);
      checkOutput("t3_frozen_no_line", done_cnt - lines0, 0);
      runFrame(2, 0, 1'b0, 1'b0);
      checkOutput("t3_resumed_line", done_cnt - lines0, 1);
      checkOutput("t3_top_row_wrap", int'(top_row), 0);

      // Downward scrolling from row 0
      runFrame(0, 1, 1'b0, 1'b0);
      checkOutput("t4_top_row_3", int'(top_row), 3);
      checkOutput("t4_mem24", int'(fb_mem[24]), 10);
      checkOutput("t4_mem29", int'(fb_mem[29]), 15);
      runFrame(0, 1, 1'b0, 1'b0);
      checkOutput("t4_top_row_2", int'(top_row), 2);
      checkOutput("t4_mem16", int'(fb_mem[16]), 10);

      // Video address mapping with top_row=1
      runFrame(0, 1, 1'b0, 1'b0);
      checkOutput("t5_top_row_1", int'(top_row), 1);
      applyStimulus(5, 3, 5);
      applyStimulus(5, 2, 29);

      // Clear request, then reset in the middle of a line write
      runFrame(0, 0, 1'b0, 1'b1);
      checkOutput("t6_top_after_clear", int'(top_row), 0);
      scroll_div = '0;
      scroll_dir = 1'b0;
      freeze     = 1'b0;
      applyStimulus(2, 1, -1);
      pushLine(m_top);
      lines0 = done_cnt;
      @(posedge clk);
      #1 lower_blank = 1'b1;
      repeat (6) @(posedge clk);
      #1 resetn = 1'b0;
      #2;
      checkOutput("t6_async_reset_wen", int'(fb_wen), 0);
      exp_q.delete();
      m_top  = 0;
      m_cnt  = 0;
      m_pend = 1'b0;
      pushClear();
      busy0 = busy_cnt;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (BLANK_CYC) @(posedge clk);
      #1 lower_blank = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("t6_clear_writes_drained", exp_q.size(), 0);
      checkOutput("t6_clear_busy_cycles", busy_cnt - busy0, 32);
      checkOutput("t6_no_line_done", done_cnt - lines0, 0);
      checkOutput("t6_top_row", int'(top_row), 0);
      checkOutput("t6_mem1_cleared", int'(fb_mem[1]), 0);
      checkOutput("t6_mem2_cleared", int'(fb_mem[2]), 0);
      runFrame(0, 0, 1'b0, 1'b0);
      checkOutput("t6_first_line_after", int'(top_row), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
